// File: rtl/game_ram_sequencer.sv
// game_ram_sequencer: owns the two-player game phase and drives the shared morse RAM port.
// Latency: write ack 1 cycle after request; read data/valid 3 edges after request (2-cycle RAM path).
// Backpressure: reads are accepted only when no read is in flight; writes beyond depth set overflow.
module game_ram_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              done,
  input  logic              p1_wr_req,
  input  logic [DATA_W-1:0] p1_wr_data,
  output logic              p1_wr_ack,
  input  logic              p2_rd_req,
  output logic [DATA_W-1:0] p2_rd_data,
  output logic              p2_rd_valid,
  input  logic              p2_miss,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [1:0]        phase,
  output logic [ADDR_W:0]   length,
  output logic [ADDR_W:0]   rd_ptr,
  output logic              full,
  output logic              overflow,
  output logic              rd_busy,
  output logic              complete,
  output logic              correct
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << ADDR_W);

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_P1     = 2'd1,
    PH_P2     = 2'd2,
    PH_RESULT = 2'd3
  } phase_e;

  phase_e              phase_q, phase_d;
  logic [CNT_W-1:0]    length_q, length_d;
  logic [CNT_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic                complete_q, complete_d;
  logic                miss_q, miss_d;
  logic                correct_q, correct_d;
  // rd_busy_q covers the whole read; rd_wait_q marks the cycle where the RAM is still sampling.
  logic                rd_busy_q, rd_busy_d;
  logic                rd_wait_q, rd_wait_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic                ram_wren_q, ram_wren_d;
  logic                p1_wr_ack_q, p1_wr_ack_d;
  logic [DATA_W-1:0]   p2_rd_data_q, p2_rd_data_d;
  logic                p2_rd_valid_q, p2_rd_valid_d;

  // Next-state: phase transitions, write/read sequencing and status flags.
  always_comb begin
    phase_d       = phase_q;
    length_d      = length_q;
    rd_ptr_d      = rd_ptr_q;
    overflow_d    = overflow_q;
    complete_d    = complete_q;
    miss_d        = miss_q;
    rd_busy_d     = rd_busy_q;
    rd_wait_d     = rd_wait_q;
    ram_addr_d    = ram_addr_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    p1_wr_ack_d   = 1'b0;
    p2_rd_data_d  = p2_rd_data_q;
    p2_rd_valid_d = 1'b0;

    case (phase_q)
      PH_IDLE, PH_RESULT: begin
        if (start) begin
          phase_d    = PH_P1;
          length_d   = '0;
          rd_ptr_d   = '0;
          overflow_d = 1'b0;
          complete_d = 1'b0;
          miss_d     = 1'b0;
        end
      end

      PH_P1: begin
        if (p1_wr_req) begin
          if (length_q != DEPTH) begin
            ram_addr_d  = length_q[ADDR_W-1:0];
            ram_data_d  = p1_wr_data;
            ram_wren_d  = 1'b1;
            p1_wr_ack_d = 1'b1;
            length_d    = length_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        // A write in the same cycle counts toward the length checked here.
        if (done && (length_d != '0)) begin
          phase_d  = PH_P2;
          rd_ptr_d = '0;
        end
      end

      PH_P2: begin
        if (p2_miss) begin
          miss_d = 1'b1;
        end
        if (rd_busy_q) begin
          if (rd_wait_q) begin
            rd_wait_d = 1'b0;
          end else begin
            rd_busy_d     = 1'b0;
            p2_rd_data_d  = ram_q;
            p2_rd_valid_d = 1'b1;
            rd_ptr_d      = rd_ptr_q + 1'b1;
            if (rd_ptr_d == length_q) begin
              complete_d = 1'b1;
              phase_d    = PH_RESULT;
            end
          end
        end else if (p2_rd_req && (rd_ptr_q < length_q)) begin
          ram_addr_d = rd_ptr_q[ADDR_W-1:0];
          rd_busy_d  = 1'b1;
          rd_wait_d  = 1'b1;
        end
        // Early done abandons any in-flight read without reporting it.
        if (done && !complete_d) begin
          phase_d       = PH_RESULT;
          rd_busy_d     = 1'b0;
          rd_wait_d     = 1'b0;
          p2_rd_valid_d = 1'b0;
          rd_ptr_d      = rd_ptr_q;
          p2_rd_data_d  = p2_rd_data_q;
        end
      end

      default: phase_d = PH_IDLE;
    endcase

    correct_d = (phase_d == PH_RESULT) && complete_d && !miss_d;
  end

  // State register with synchronous reset; reset aborts any pending write or read.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q       <= PH_IDLE;
      length_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      complete_q    <= 1'b0;
      miss_q        <= 1'b0;
      correct_q     <= 1'b0;
      rd_busy_q     <= 1'b0;
      rd_wait_q     <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      p1_wr_ack_q   <= 1'b0;
      p2_rd_data_q  <= '0;
      p2_rd_valid_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      length_q      <= length_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
      complete_q    <= complete_d;
      miss_q        <= miss_d;
      correct_q     <= correct_d;
      rd_busy_q     <= rd_busy_d;
      rd_wait_q     <= rd_wait_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      p1_wr_ack_q   <= p1_wr_ack_d;
      p2_rd_data_q  <= p2_rd_data_d;
      p2_rd_valid_q <= p2_rd_valid_d;
    end
  end

  assign phase       = phase_q;
  assign length      = length_q;
  assign rd_ptr      = rd_ptr_q;
  assign full        = (length_q == DEPTH);
  assign overflow    = overflow_q;
  assign complete    = complete_q;
  assign correct     = correct_q;
  assign rd_busy     = rd_busy_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign p1_wr_ack   = p1_wr_ack_q;
  assign p2_rd_data  = p2_rd_data_q;
  assign p2_rd_valid = p2_rd_valid_q;

endmodule

// File: tb/tb_game_ram_sequencer.sv
// Bench for game_ram_sequencer: a game-level model predicts acks and reads into queues,
// a negedge monitor pops and compares them, and status checks run between game steps.
module tb_game_ram_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, done, p1_wr_req, p2_rd_req, p2_miss;
  logic [9:0] p1_wr_data;
  logic       p1_wr_ack, p2_rd_valid, ram_wren;
  logic [9:0] p2_rd_data, ram_data;
  logic [9:0] ram_q;
  logic [3:0] ram_addr;
  logic [1:0] phase;
  logic [4:0] length, rd_ptr;
  logic       full, overflow, rd_busy, complete, correct;

  game_ram_sequencer #(.ADDR_W(4), .DATA_W(10)) dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .p1_wr_req(p1_wr_req), .p1_wr_data(p1_wr_data), .p1_wr_ack(p1_wr_ack),
    .p2_rd_req(p2_rd_req), .p2_rd_data(p2_rd_data), .p2_rd_valid(p2_rd_valid),
    .p2_miss(p2_miss), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .phase(phase), .length(length), .rd_ptr(rd_ptr), .full(full),
    .overflow(overflow), .rd_busy(rd_busy), .complete(complete), .correct(correct)
  );

  always #5 clock = ~clock;

  // Single-port RAM with a one-cycle synchronous read.
  logic [9:0] mem [16];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [9:0]  data;
    logic [31:0] cyc;
  } wr_exp_t;
  typedef struct packed {
    logic [9:0]  data;
    logic [31:0] cyc;
  } rd_exp_t;

  wr_exp_t exp_wr[$];
  rd_exp_t exp_rd[$];
  wr_exp_t mon_we;
  rd_exp_t mon_re;

  // Game-level model.
  int         m_phase;
  logic [9:0] m_words[$];
  int         m_rdptr;
  bit         m_ovf, m_miss, m_cmp;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    m_words.delete();
    m_rdptr = 0;
    m_ovf = 0;
    m_miss = 0;
    m_cmp = 0;
  endtask

  // Monitor: every ack or read-valid must match the head of its expectation queue.
  always @(negedge clock) begin
    if (ram_wren || p1_wr_ack) chk("wren_with_ack", int'(ram_wren), int'(p1_wr_ack));
    if (p1_wr_ack) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        mon_we = exp_wr.pop_front();
        chk("wr_addr", int'(ram_addr), int'(mon_we.addr));
        chk("wr_data", int'(ram_data), int'(mon_we.data));
        chk("wr_ack_cycle", cyc, int'(mon_we.cyc));
      end
    end
    if (p2_rd_valid) begin
      if (exp_rd.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_re = exp_rd.pop_front();
        chk("rd_data", int'(p2_rd_data), int'(mon_re.data));
        chk("rd_valid_cycle", cyc, int'(mon_re.cyc));
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    if (m_phase == 0 || m_phase == 3) begin
      m_phase = 1;
      model_clear();
    end
    tick();
    start = 1'b0;
  endtask

  task automatic do_done();
    done = 1'b1;
    if (m_phase == 1 && m_words.size() > 0) begin
      m_phase = 2;
      m_rdptr = 0;
    end else if (m_phase == 2) begin
      m_phase = 3;
    end
    tick();
    done = 1'b0;
  endtask

  task automatic p1_write(input logic [9:0] d, input bit with_done);
    wr_exp_t e;
    p1_wr_req = 1'b1;
    p1_wr_data = d;
    done = with_done;
    if (m_phase == 1) begin
      if (m_words.size() < 16) begin
        e.addr = 4'(m_words.size());
        e.data = d;
        e.cyc = 32'(cyc + 1);
        exp_wr.push_back(e);
        m_words.push_back(d);
      end else begin
        m_ovf = 1;
      end
      if (with_done && m_words.size() > 0) begin
        m_phase = 2;
        m_rdptr = 0;
      end
    end
    tick();
    p1_wr_req = 1'b0;
    done = 1'b0;
    if (exp_wr.size() != 0) tick();
    if (exp_wr.size() != 0) begin
      chk("wr_ack_timeout", exp_wr.size(), 0);
      exp_wr.delete();
    end
  endtask

  task automatic p2_read(input bit miss_mid, input bit double_req);
    rd_exp_t e;
    int n;
    p2_rd_req = 1'b1;
    if (m_phase == 2 && m_rdptr < m_words.size()) begin
      e.data = m_words[m_rdptr];
      e.cyc = 32'(cyc + 3);
      exp_rd.push_back(e);
      m_rdptr++;
    end
    tick();
    p2_rd_req = double_req;
    p2_miss = miss_mid;
    if (miss_mid && m_phase == 2) m_miss = 1;
    tick();
    p2_rd_req = 1'b0;
    p2_miss = 1'b0;
    n = 0;
    while (exp_rd.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    if (exp_rd.size() != 0) begin
      chk("rd_valid_timeout", exp_rd.size(), 0);
      exp_rd.delete();
    end
    if (m_phase == 2 && m_rdptr == m_words.size()) begin
      m_cmp = 1;
      m_phase = 3;
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_phase"}, int'(phase), m_phase);
    chk({tag, "_length"}, int'(length), m_words.size());
    chk({tag, "_rd_ptr"}, int'(rd_ptr), m_rdptr);
    chk({tag, "_full"}, int'(full), int'(m_words.size() == 16));
    chk({tag, "_overflow"}, int'(overflow), int'(m_ovf));
    chk({tag, "_complete"}, int'(complete), int'(m_cmp));
    chk({tag, "_correct"}, int'(correct), int'(m_phase == 3 && m_cmp && !m_miss));
    chk({tag, "_rd_busy"}, int'(rd_busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [9:0] d;
    reset = 1'b1;
    start = 0; done = 0; p1_wr_req = 0; p2_rd_req = 0; p2_miss = 0; p1_wr_data = '0;
    m_phase = 0;
    model_clear();
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check_status("reset");
    chk("reset_ram_addr", int'(ram_addr), 0);
    chk("reset_ram_data", int'(ram_data), 0);
    chk("reset_ram_wren", int'(ram_wren), 0);
    chk("reset_ack", int'(p1_wr_ack), 0);
    chk("reset_valid", int'(p2_rd_valid), 0);
    chk("reset_rd_data", int'(p2_rd_data), 0);

    // Reset while a read is in flight: nothing may be reported afterwards.
    do_start();
    p1_write(10'h03C, 1'b0);
    do_done();
    p2_rd_req = 1'b1;
    tick();
    p2_rd_req = 1'b0;
    chk("midread_busy", int'(rd_busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_phase = 0;
    model_clear();
    check_status("midread_reset");
    repeat (4) tick();

    // Basic game.
    do_start();
    p1_write(10'h155, 1'b0);
    p1_write(10'h2AA, 1'b0);
    p1_write(10'h001, 1'b0);
    do_done();
    check_status("basic_p2");
    for (int i = 0; i < 3; i++) p2_read(1'b0, 1'b0);
    check_status("basic_result");

    // done with nothing written is ignored; write+done together enters P2.
    do_start();
    do_done();
    check_status("empty_done");
    p1_write(10'h2F0, 1'b1);
    check_status("wr_and_done");
    p2_read(1'b0, 1'b1);
    check_status("double_req");

    // Overflow: 17 writes, 16 accepted.
    do_start();
    for (int i = 0; i < 17; i++) p1_write(10'($urandom_range(0, 1023)), 1'b0);
    check_status("overflow_p1");
    do_done();
    for (int i = 0; i < 16; i++) p2_read(1'b0, 1'b0);
    check_status("overflow_result");

    // Restart from RESULT clears length and overflow.
    do_start();
    check_status("restart");

    // Early done after one read.
    for (int i = 0; i < 3; i++) p1_write(10'($urandom_range(0, 1023)), 1'b0);
    do_done();
    p2_read(1'b0, 1'b0);
    do_done();
    check_status("early_done");

    // Miss during a read of a complete game.
    do_start();
    for (int i = 0; i < 3; i++) p1_write(10'($urandom_range(0, 1023)), 1'b0);
    do_done();
    p2_read(1'b0, 1'b0);
    p2_read(1'b1, 1'b0);
    p2_read(1'b0, 1'b0);
    check_status("miss");

    // Randomized games.
    for (int g = 0; g < 6; g++) begin
      do_start();
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        d = 10'($urandom_range(0, 1023));
        p1_write(d, 1'b0);
      end
      do_done();
      for (int i = 0; i < n; i++) p2_read(($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1));
      check_status("rand_game");
    end

    repeat (3) tick();
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
